// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Declarations shared by the execute-stage divide unit, its interface and its
// testbench.
//   div_op_e    : operation encoding carried on the 2-bit op field
//   div_state_e : divider sequencer states
//   DIV_ITERS   : iteration count of a full-width divide (equals DATA_WIDTH)
//   MIN_INT     : most negative 32-bit value (dividend of signed overflow)
//   NEG_ONE     : all-ones 32-bit value (divisor of signed overflow)
// Optional feature macro used by the divide unit: DIV_EARLY_OUT_EN
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] MIN_INT   = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // DIV and REM interpret operands as two's complement.
    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient.
    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// ---------------------------------------------------------------------------
// ex_div_unit_if
// Connection between the execute stage and the divide unit.
//   start  : divide op present in EX this cycle
//   op     : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   RD1E   : dividend          RD2E : divisor          RdE : destination reg
//   flush  : abort the current operation (branch/jump flush)
//   busy   : unit not idle     stall : freeze IF/ID, ID/EX and PC
//   done   : one-cycle pulse, result and RdOut valid
//   result : quotient or remainder
//   RdOut  : destination register of the completed operation
// Modports: master = execute-stage side, slave = divide unit.
// ---------------------------------------------------------------------------
interface ex_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [4:0]            RdE;
    logic                  flush;
    logic                  busy;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [4:0]            RdOut;

    modport master (
        output start, op, RD1E, RD2E, RdE, flush,
        input  busy, stall, done, result, RdOut
    );

    modport slave (
        input  start, op, RD1E, RD2E, RdE, flush,
        output busy, stall, done, result, RdOut
    );
endinterface

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration. The {rem, quo} pair is
// shifted left by one, pulling the next dividend bit (quo MSB) into the
// partial remainder; the divisor is trial-subtracted and the difference kept
// when it is non-negative, in which case the new quotient LSB is 1.
//   rem      : partial remainder (always < dvs on entry)
//   quo      : quotient bits so far, unshifted dividend bits in the upper part
//   dvs      : divisor magnitude (non-zero)
//   rem_next : partial remainder after this step
//   quo_next : quotient after this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] dvs,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);
    // One extra bit: the shifted remainder can reach 2*dvs-1, and the MSB of
    // the difference is the borrow that says the subtraction went negative.
    logic [DATA_WIDTH:0] trial;

    // NOTE: every output gets a value on every path through always_comb,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        trial    = {rem, quo[DATA_WIDTH-1]} - {1'b0, dvs};
        rem_next = {rem[DATA_WIDTH-2:0], quo[DATA_WIDTH-1]};
        quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
        if (!trial[DATA_WIDTH]) begin
            rem_next = trial[DATA_WIDTH-1:0];
            quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/ex_div_unit.sv
// ---------------------------------------------------------------------------
// ex_div_unit
// Iterative integer divide/remainder unit in the execute stage. Accepts a
// divide op from ID/EX, stalls the front of the pipeline while it performs
// DATA_WIDTH restoring-division steps, then pulses done for one cycle with
// the result and destination register for the EX/MEM path.
// Divide-by-zero and signed overflow complete one cycle after start.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ex_div_unit_if.slave (start/op/operands/flush in, status/result out)
// Parameters:
//   DATA_WIDTH : operand/result width (<= 32), also the iteration count
// Build option:
//   DIV_EARLY_OUT_EN : when defined, |divisor| > |dividend| completes one
//                      cycle after start (quotient 0, remainder = dividend).
// ---------------------------------------------------------------------------
module ex_div_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_ITERS
) (
    input logic           clk,
    input logic           rst,
    ex_div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  = DATA_WIDTH'(MIN_INT >> (DIV_ITERS - DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = DATA_WIDTH'(NEG_ONE);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
    div_op_e               op_q;
    logic [4:0]            rd_q;
    logic                  q_neg_q, r_neg_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [4:0]            rd_out_q;
    logic                  stall;

    // Operand decode for the op presented in IDLE
    div_op_e               op_in;
    logic                  in_signed, dvd_neg, dvs_neg, q_neg;
    logic                  div_zero, ovf, early, fast, accept;
    logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag, fast_result;

    // Iteration datapath
    logic [DATA_WIDTH-1:0] rem_n, quo_n, calc_result;

    // Applies the sign rules to unsigned magnitudes: DIV quotient is negative
    // when the operand signs differ, REM remainder follows the dividend.
    function automatic logic [DATA_WIDTH-1:0] pick_result(
        input div_op_e               op,
        input logic [DATA_WIDTH-1:0] q,
        input logic [DATA_WIDTH-1:0] r,
        input logic                  qn,
        input logic                  rn
    );
        logic [DATA_WIDTH-1:0] res;
        case (op)
            OP_DIV:  res = qn ? -q : q;
            OP_REM:  res = rn ? -r : r;
            OP_DIVU: res = q;
            default: res = r;
        endcase
        return res;
    endfunction

    always_comb begin
        op_in     = div_op_e'(bus.op);
        in_signed = op_is_signed(op_in);
        dvd_neg   = in_signed & bus.RD1E[DATA_WIDTH-1];
        dvs_neg   = in_signed & bus.RD2E[DATA_WIDTH-1];
        q_neg     = dvd_neg ^ dvs_neg;
        dvd_mag   = dvd_neg ? -bus.RD1E : bus.RD1E;
        dvs_mag   = dvs_neg ? -bus.RD2E : bus.RD2E;
        div_zero  = (bus.RD2E == '0);
        ovf       = in_signed && (bus.RD1E == MIN_VAL) && (bus.RD2E == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
        // A non-zero divisor is implied: dvs_mag > dvd_mag >= 0.
        early     = (dvs_mag > dvd_mag);
`else
        early     = 1'b0;
`endif
        fast      = div_zero | ovf | early;
        accept    = (state_q == S_IDLE) && bus.start && !bus.flush;

        if (div_zero) begin
            fast_result = op_is_rem(op_in) ? bus.RD1E : ALL_ONES;
        end else if (ovf) begin
            fast_result = op_is_rem(op_in) ? '0 : MIN_VAL;
        end else begin
            // Early out: quotient 0, remainder is the dividend magnitude.
            fast_result = pick_result(op_in, '0, dvd_mag, q_neg, dvd_neg);
        end
    end

    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .dvs      (dvs_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    assign calc_result = pick_result(op_q, quo_n, rem_n, q_neg_q, r_neg_q);

    // Next-state and stall
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall   = 1'b1;
                    state_d = fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;   // DONE lasts one cycle; starts here are ignored
        endcase
    end

    // NOTE: all sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_q     <= OP_DIV;
            rd_q     <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        rd_q    <= bus.RdE;
                        q_neg_q <= q_neg;
                        r_neg_q <= dvd_neg;
                        rem_q   <= '0;
                        quo_q   <= dvd_mag;
                        dvs_q   <= dvs_mag;
                        cnt_q   <= CNT_W'(DATA_WIDTH - 1);
                        if (fast) begin
                            result_q <= fast_result;
                            rd_out_q <= bus.RdE;
                        end
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        rem_q <= rem_n;
                        quo_q <= quo_n;
                        cnt_q <= cnt_q - 1'b1;
                        // The last step's outputs go straight to the result
                        // register so they are valid throughout DONE.
                        if (cnt_q == '0) begin
                            result_q <= calc_result;
                            rd_out_q <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.stall  = stall;
    assign bus.result = result_q;
    assign bus.RdOut  = rd_out_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_div_unit
// Directed self-checking bench for ex_div_unit: signed/unsigned quotient and
// remainder, divide-by-zero, signed overflow, flush, reset mid-operation,
// start while busy, start in the DONE cycle and the DIV_EARLY_OUT_EN latency.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_div_unit;
    import muldiv_pkg::*;

    localparam int NLAT = DIV_ITERS + 1;   // full iteration latency
    localparam int FLAT = 1;               // fast path latency
`ifdef DIV_EARLY_OUT_EN
    localparam int ELAT = FLAT;
`else
    localparam int ELAT = NLAT;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ex_div_unit_if #(.DATA_WIDTH(32)) bus ();

    ex_div_unit #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one op for a single cycle starting at a negedge; st is the
    // stall level seen during that start cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int st);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.RD1E  = a;
        bus.RD2E  = b;
        bus.RdE   = rd;
        #1 st = int'(bus.stall);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; lat counts cycles after the
    // start cycle, stl counts stall cycles before done.
    task automatic wait_done(output int lat, output int stl, output logic got);
        lat = 0;
        stl = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            stl += int'(bus.stall);
        end
    endtask

    task automatic run_div(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int exp_lat);
        int   st, lat, stl;
        logic got;
        issue(o, a, b, rd, st);
        wait_done(lat, stl, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_result"}, bus.result, exp_res);
        check({tag, "_rd"}, 32'(bus.RdOut), 32'(rd));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(st + stl), 32'(exp_lat));
        check({tag, "_stall_in_done"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int   st, lat, stl, seen;
        logic got;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.RD1E  = '0;
        bus.RD2E  = '0;
        bus.RdE   = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_busy",   32'(bus.busy),  32'd0);
        check("rst_stall",  32'(bus.stall), 32'd0);
        check("rst_done",   32'(bus.done),  32'd0);
        check("rst_result", bus.result,     32'd0);
        check("rst_rdout",  32'(bus.RdOut), 32'd0);

        // Main function, full latency
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, NLAT);
        run_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 32'd2,  NLAT);
        run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, NLAT);
        run_div("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, NLAT);
        run_div("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, NLAT);
        run_div("div_100_m7", OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd10, 32'hFFFF_FFF2, NLAT);
        run_div("rem_100_m7", OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd11, 32'd2, NLAT);
        run_div("div_min_2",  OP_DIV,  MIN_INT, 32'd2, 5'd12, 32'hC000_0000, NLAT);
        run_div("divu_max_1", OP_DIVU, NEG_ONE, 32'd1, 5'd13, 32'hFFFF_FFFF, NLAT);
        run_div("remu_max_m2", OP_REMU, NEG_ONE, 32'hFFFF_FFFE, 5'd14, 32'd1, NLAT);

        // Fast path: divide by zero and signed overflow
        run_div("divu_5_0",  OP_DIVU, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, FLAT);
        run_div("remu_5_0",  OP_REMU, 32'd5, 32'd0, 5'd16, 32'd5, FLAT);
        run_div("div_m5_0",  OP_DIV,  32'hFFFF_FFFB, 32'd0, 5'd17, 32'hFFFF_FFFF, FLAT);
        run_div("rem_m5_0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFB, FLAT);
        run_div("div_ovf",   OP_DIV,  MIN_INT, NEG_ONE, 5'd19, MIN_INT, FLAT);
        run_div("rem_ovf",   OP_REM,  MIN_INT, NEG_ONE, 5'd20, 32'd0, FLAT);

        // Divisor magnitude larger than dividend magnitude
        run_div("divu_3_10", OP_DIVU, 32'd3, 32'd10, 5'd21, 32'd0, ELAT);
        run_div("remu_3_10", OP_REMU, 32'd3, 32'd10, 5'd22, 32'd3, ELAT);
        run_div("rem_m3_10", OP_REM,  32'hFFFF_FFFD, 32'd10, 5'd23, 32'hFFFF_FFFD, ELAT);

        // Flush 10 cycles into CALC: no done, result keeps 0xFFFFFFFD
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd3, st);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush_busy",  32'(bus.busy),  32'd0);
        check("flush_stall", 32'(bus.stall), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen += int'(bus.done);
        end
        check("flush_no_done", 32'(seen), 32'd0);
        check("flush_result_held", bus.result, 32'hFFFF_FFFD);
        run_div("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, NLAT);

        // flush together with start: not accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_DIVU;
        bus.RD1E  = 32'd50;
        bus.RD2E  = 32'd5;
        #1 check("startflush_stall", 32'(bus.stall), 32'd0);
        @(posedge clk);
        #1 begin
            bus.start = 1'b0;
            bus.flush = 1'b0;
        end
        @(negedge clk);
        check("startflush_busy", 32'(bus.busy), 32'd0);

        // start while busy with other operands: ignored
        issue(OP_DIVU, 32'd100, 32'd7, 5'd5, st);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_REMU;
        bus.RD1E  = 32'd200;
        bus.RD2E  = 32'd3;
        bus.RdE   = 5'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat, stl, got);
        check("busy_start_done_seen", 32'(got), 32'd1);
        check("busy_start_result", bus.result, 32'd14);
        check("busy_start_rd", 32'(bus.RdOut), 32'd5);

        // start during the DONE cycle: ignored
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.RD1E  = 32'd8;
        bus.RD2E  = 32'd2;
        bus.RdE   = 5'd1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("done_start_busy", 32'(bus.busy), 32'd0);
        check("done_start_result_held", bus.result, 32'd14);

        // rst 5 cycles into CALC: everything cleared
        issue(OP_DIVU, 32'd77, 32'd4, 5'd30, st);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",   32'(bus.busy),  32'd0);
        check("midrst_stall",  32'(bus.stall), 32'd0);
        check("midrst_done",   32'(bus.done),  32'd0);
        check("midrst_result", bus.result,     32'd0);
        check("midrst_rdout",  32'(bus.RdOut), 32'd0);
        run_div("divu_77_4_after_rst", OP_DIVU, 32'd77, 32'd4, 5'd30, 32'd19, NLAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative 32-bit integer divide/remainder unit in the execute stage, directly downstream of the ID/EX pipeline register.
- It consumes the register operands latched into execute (RD1E, RD2E, RdE) when decode flags an M-extension divide op.
- Holds the pipeline via a stall output while it iterates, then presents the result and destination register for one cycle to the EX/MEM path.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  divide op present in EX this cycle; sampled only in IDLE
op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
RD1E  in  DATA_WIDTH  dividend
RD2E  in  DATA_WIDTH  divisor
RdE  in  5  destination register
flush  in  1  abort current operation (branch/jump flush)
busy  out  1  state != IDLE
stall  out  1  freeze IF/ID, ID/EX and PC
done  out  1  one-cycle pulse, result valid
result  out  DATA_WIDTH  quotient or remainder per latched op
RdOut  out  5  latched RdE, valid with done

Behaviour:
- Reset (synchronous, active-high rst): state=IDLE; busy=0, stall=0, done=0, result=0, RdOut=0; iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0: latch op, RdE, sign flags. Convert operands to magnitudes for DIV/REM (two's-complement negate if MSB set); DIVU/REMU use operands raw.
  - Normal path: go to CALC with counter=DATA_WIDTH-1.
  - Fast path: divisor==0, or signed overflow (DIV/REM with dividend=0x80000000, divisor=0xFFFFFFFF): go straight to DONE.
- CALC: one restoring-division step per cycle, MSB first. Shift {rem,quo} left 1, trial-subtract divisor; if non-negative keep the difference and set quo LSB=1. Counter decrements; after the step at counter==0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored; the op is re-presented after the pipeline advances.
- Result selection:
  - DIV: quotient negated when the signed operand signs differ.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: raw quotient/remainder.
- Divide by zero: quotient=all ones, remainder=dividend (unsigned and signed).
- Signed overflow: quotient=0x80000000, remainder=0.
- stall = (IDLE & start & ~flush) | CALC, combinational. It is 0 in DONE, so the pipeline advances on the edge that consumes result.
- Latency: normal path done asserts DATA_WIDTH+1 cycles after the start cycle (33 for default). Fast path asserts 1 cycle after.
- start while busy: ignored; operands are not re-latched.
- flush in any state: next state IDLE, done stays 0, result unchanged. flush in the same cycle as start takes priority, so the start is not accepted.
- rst mid-operation: behaves like flush and also clears outputs.
- result and RdOut hold their last value outside DONE.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if divisor magnitude > dividend magnitude (divisor != 0), go straight to DONE with quotient=0 and remainder=dividend (sign rules still applied); latency 1 cycle.
- Undefined: such cases take the full DATA_WIDTH iterations.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding typedef (DIV/DIVU/REM/REMU)
  - state enum (IDLE/CALC/DONE)
  - DIV_ITERS constant
  - overflow constants MIN_INT and NEG_ONE
- One natural sub-module, div_step: combinational single iteration. Inputs: partial remainder, quotient, divisor. Outputs: next remainder, next quotient.

Test Plan:
- DIVU 100/7 (start one cycle): stall high 33 cycles, done at cycle 33, result=14. REMU same operands gives 2. RdOut=RdE (e.g. 5).
- DIV 0xFFFFFFF9/2 (-7/2): result 0xFFFFFFFD (-3). REM gives 0xFFFFFFFF (-1). REM 7/-2 gives 1.
- DIVU 5/0: result 0xFFFFFFFF, done 1 cycle after start. REMU 5/0 gives 5. DIV 0x80000000/0xFFFFFFFF gives 0x80000000. REM same operands gives 0.
- flush asserted 10 cycles into CALC: busy/stall low next cycle, no done pulse. A new start on DIVU 9/3 then yields 3 with full latency.
- start toggled high during CALC with different operands: ignored, original result returned. rst at cycle 5 of CALC: all outputs 0, IDLE next cycle.
- With DIV_EARLY_OUT_EN: DIVU 3/10 gives done after 1 cycle, result 0, REMU gives 3. Without the macro: done after 33 cycles, same values.
